// File: rtl/cpu_tg_pkg.sv
// Shared encodings for the CPU-port traffic generator: bus states, run modes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_tg_pkg;

    // cpuState bus encodings
    localparam logic [1:0] CPU_IDLE  = 2'b01;
    localparam logic [1:0] CPU_READ  = 2'b10;
    localparam logic [1:0] CPU_WRITE = 2'b11;

    // run modes
    localparam logic [1:0] MODE_WR    = 2'b00;  // write-only pass
    localparam logic [1:0] MODE_RD    = 2'b01;  // read-check pass
    localparam logic [1:0] MODE_WR_RD = 2'b10;  // write pass then read-check pass
    localparam logic [1:0] MODE_IL    = 2'b11;  // write/read interleaved per word

    // sequencer states; the gap states are named for the access that follows them
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_GAP,
        S_RD,
        S_RD_GAP,
        S_DONE
    } tg_state_t;

endpackage

// File: rtl/cpu_tg_checker.sv
// Data pattern generator and read-data checker with sticky error registers.
// Latency: pattern is combinational from the address; error registers update on the compare clock.
// Backpressure: none; compares exactly on the clocks cmp_vld is high.
module cpu_tg_checker
    import cpu_tg_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_114,
    input  logic              reset_n,
    input  logic [ADDR_W:1]   addr,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              cmp_vld,
    input  logic              clr,
    output logic [DATA_W-1:0] pat,
    output logic              err,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W:1]   err_addr
);

    logic [DATA_W-1:0] addr_ext;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [ADDR_W:1]   err_addr_q, err_addr_d;

    // low DATA_W bits of the word address, zero-extended for narrow address buses
    generate
        if (ADDR_W >= DATA_W) begin : g_trunc
            assign addr_ext = addr[DATA_W:1];
        end else begin : g_zext
            assign addr_ext = {{(DATA_W - ADDR_W){1'b0}}, addr};
        end
    endgenerate

    assign pat = addr_ext ^ seed;

    // sticky error state: cleared by a new run, err_addr keeps only the first miss
    always_comb begin
        err_d       = err_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        if (clr) begin
            err_d       = 1'b0;
            err_count_d = '0;
            err_addr_d  = '0;
        end else if (cmp_vld && (rd_data != pat)) begin
            err_d = 1'b1;
            if (!(&err_count_q)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            if (!err_q) begin
                err_addr_d = addr;
            end
        end
    end

    // error registers
    always_ff @(posedge clk_114 or negedge reset_n) begin
        if (!reset_n) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

endmodule

// File: rtl/cpu_traffic_gen.sv
// Drives write/read traffic on the CPU port of a memory controller and checks read data.
// Latency: first access on the clock after start; each access holds until ena28 && cpuena.
// Backpressure: access is held stable until acknowledged; TIMEOUT unacked clocks abort the run.
module cpu_traffic_gen
    import cpu_tg_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int THR_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_114,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              longword,
    input  logic [ADDR_W:1]   base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [THR_W-1:0]  throttle,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W:1]   cpuAddr,
    output logic [1:0]        cpuState,
    output logic              cpuL,
    output logic              cpuU,
    output logic              cpuLongWord,
    output logic [DATA_W-1:0] cpuWR,
    input  logic [DATA_W-1:0] cpuRD,
    input  logic              ena28,
    input  logic              cpuena,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W:1]   err_addr
);

    localparam int WT_W = $clog2(TIMEOUT + 1);

    tg_state_t         state_q, state_d;
    logic [ADDR_W:1]   addr_q, addr_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [THR_W-1:0]  gap_q, gap_d;
    logic [WT_W-1:0]   wait_q, wait_d;
    logic              timeout_q, timeout_d;
    // run configuration captured on start
    logic [1:0]        mode_q, mode_d;
    logic              lw_q, lw_d;
    logic [ADDR_W:1]   base_q, base_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [THR_W-1:0]  thr_q, thr_d;
    logic [DATA_W-1:0] seed_q, seed_d;

    logic              in_access;
    logic              acc_done;
    logic              last_word;
    logic              lw_eff;
    logic              pair_head;
    logic              run_start;
    tg_state_t         succ_state;
    logic [ADDR_W:1]   succ_addr;
    logic [CNT_W-1:0]  succ_idx;
    logic [DATA_W-1:0] pat;

    assign in_access = (state_q == S_WR) || (state_q == S_RD);
    assign acc_done  = in_access && ena28 && cpuena;
    assign last_word = (idx_q == num_q - CNT_W'(1));
    // interleaved mode alternates write/read per word, so pairing does not apply there
    assign lw_eff    = lw_q && (mode_q != MODE_IL);
    // even word with a partner behind it; an odd-length tail goes out as a plain word
    assign pair_head = lw_eff && !idx_q[0] && !last_word;
    assign run_start = start && (state_q == S_IDLE);

    // access that follows the one currently on the bus
    always_comb begin
        succ_state = S_DONE;
        succ_addr  = addr_q + ADDR_W'(1);
        succ_idx   = idx_q + CNT_W'(1);
        if (state_q == S_WR) begin
            if (mode_q == MODE_IL) begin
                succ_state = S_RD;
                succ_addr  = addr_q;
                succ_idx   = idx_q;
            end else if (!last_word) begin
                succ_state = S_WR;
            end else if (mode_q == MODE_WR_RD) begin
                succ_state = S_RD;
                succ_addr  = base_q;
                succ_idx   = '0;
            end
        end else if (!last_word) begin
            succ_state = (mode_q == MODE_IL) ? S_WR : S_RD;
        end
    end

    // sequencer next-state, pacing and timeout
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        mode_d    = mode_q;
        lw_d      = lw_q;
        base_d    = base_q;
        num_d     = num_q;
        thr_d     = thr_q;
        seed_d    = seed_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    lw_d      = longword;
                    base_d    = base_addr;
                    num_d     = num_words;
                    thr_d     = throttle;
                    seed_d    = seed;
                    addr_d    = base_addr;
                    idx_d     = '0;
                    wait_d    = '0;
                    timeout_d = 1'b0;
                    if (num_words == '0) begin
                        state_d = S_DONE;
                    end else if (mode == MODE_RD) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR, S_RD: begin
                if (acc_done) begin
                    wait_d = '0;
                    addr_d = succ_addr;
                    idx_d  = succ_idx;
                    if ((succ_state == S_DONE) || (thr_q == '0) || pair_head) begin
                        state_d = succ_state;
                    end else begin
                        state_d = (succ_state == S_WR) ? S_WR_GAP : S_RD_GAP;
                        gap_d   = thr_q - THR_W'(1);
                    end
                end else if (wait_q == WT_W'(TIMEOUT)) begin
                    wait_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wait_d = wait_q + WT_W'(1);
                end
            end
            S_WR_GAP: begin
                if (gap_q == '0) state_d = S_WR;
                else             gap_d   = gap_q - THR_W'(1);
            end
            S_RD_GAP: begin
                if (gap_q == '0) state_d = S_RD;
                else             gap_d   = gap_q - THR_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // sequencer registers
    always_ff @(posedge clk_114 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            mode_q    <= MODE_WR;
            lw_q      <= 1'b0;
            base_q    <= '0;
            num_q     <= '0;
            thr_q     <= '0;
            seed_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            mode_q    <= mode_d;
            lw_q      <= lw_d;
            base_q    <= base_d;
            num_q     <= num_d;
            thr_q     <= thr_d;
            seed_q    <= seed_d;
        end
    end

    // bus state follows the sequencer state; everything else reads as idle
    always_comb begin
        cpuState = CPU_IDLE;
        if (state_q == S_WR)      cpuState = CPU_WRITE;
        else if (state_q == S_RD) cpuState = CPU_READ;
    end

    cpu_tg_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_checker (
        .clk_114   (clk_114),
        .reset_n   (reset_n),
        .addr      (addr_q),
        .seed      (seed_q),
        .rd_data   (cpuRD),
        .cmp_vld   (acc_done && (state_q == S_RD)),
        .clr       (run_start),
        .pat       (pat),
        .err       (err),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    assign cpuAddr     = addr_q;
    assign cpuL        = !in_access;
    assign cpuU        = !in_access;
    assign cpuLongWord = in_access && pair_head;
    assign cpuWR       = (state_q == S_WR) ? pat : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
module tb_cpu_traffic_gen;

    logic        clk_114 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        longword = 1'b0;
    logic [23:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic [3:0]  throttle = '0;
    logic [15:0] seed = '0;
    logic [23:0] cpuAddr;
    logic [1:0]  cpuState;
    logic        cpuL, cpuU, cpuLongWord;
    logic [15:0] cpuWR;
    logic [15:0] cpuRD = '0;
    logic        ena28 = 1'b1;
    logic        cpuena = 1'b1;
    logic        busy, done, err, timeout;
    logic [15:0] err_count;
    logic [23:0] err_addr;

    always #5 clk_114 = ~clk_114;

    cpu_traffic_gen #(
        .ADDR_W(24), .DATA_W(16), .CNT_W(16), .THR_W(4), .TIMEOUT(16)
    ) dut (
        .clk_114(clk_114), .reset_n(reset_n), .start(start), .mode(mode),
        .longword(longword), .base_addr(base_addr), .num_words(num_words),
        .throttle(throttle), .seed(seed), .cpuAddr(cpuAddr), .cpuState(cpuState),
        .cpuL(cpuL), .cpuU(cpuU), .cpuLongWord(cpuLongWord), .cpuWR(cpuWR),
        .cpuRD(cpuRD), .ena28(ena28), .cpuena(cpuena), .busy(busy), .done(done),
        .err(err), .timeout(timeout), .err_count(err_count), .err_addr(err_addr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // memory model and bus monitor
    logic [15:0] mem [logic [23:0]];
    bit          unwr_good = 1'b0;   // unwritten words read back as the correct pattern
    bit          ovr_en = 1'b0;
    logic [23:0] ovr_addr = '0;
    logic [15:0] ovr_val = '0;
    logic [23:0] log_addr[$];
    logic [1:0]  log_st[$];
    logic        log_lw[$];
    logic [15:0] log_wd[$];
    int          log_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          issue_cyc = -1;

    function automatic logic [15:0] exp_pat(input logic [23:0] a, input logic [15:0] s);
        return a[15:0] ^ s;
    endfunction

    always @(negedge clk_114) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpuState != 2'b01 && issue_cyc < 0) issue_cyc = cyc;
        if (mem.exists(cpuAddr))                cpuRD = mem[cpuAddr];
        else if (ovr_en && cpuAddr == ovr_addr) cpuRD = ovr_val;
        else if (unwr_good)                     cpuRD = exp_pat(cpuAddr, seed);
        else                                    cpuRD = 16'hDEAD;
        if (cpuState != 2'b01 && ena28 && cpuena) begin
            log_addr.push_back(cpuAddr);
            log_st.push_back(cpuState);
            log_lw.push_back(cpuLongWord);
            log_wd.push_back(cpuWR);
            log_cyc.push_back(cyc);
            if (cpuState == 2'b11) mem[cpuAddr] = cpuWR;
        end
    end

    task automatic start_run(input logic [1:0] m, input logic lw, input logic [23:0] b,
                             input logic [15:0] n, input logic [3:0] thr, input logic [15:0] s);
        @(posedge clk_114);
        #1;
        mode = m; longword = lw; base_addr = b; num_words = n; throttle = thr; seed = s;
        log_addr.delete(); log_st.delete(); log_lw.delete(); log_wd.delete(); log_cyc.delete();
        done_cnt = 0;
        issue_cyc = -1;
        start = 1'b1;
        @(posedge clk_114);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_114);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, " done reached"}, 32'(seen), 32'd1);
        repeat (2) @(negedge clk_114);
        check_eq({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " busy after done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " cpuState"}, 32'(cpuState), 32'h1);
        check_eq({tag, " cpuL"}, 32'(cpuL), 32'h1);
        check_eq({tag, " cpuU"}, 32'(cpuU), 32'h1);
        check_eq({tag, " cpuLongWord"}, 32'(cpuLongWord), 32'h0);
        check_eq({tag, " cpuAddr"}, 32'(cpuAddr), 32'h0);
        check_eq({tag, " cpuWR"}, 32'(cpuWR), 32'h0);
        check_eq({tag, " busy"}, 32'(busy), 32'h0);
        check_eq({tag, " done"}, 32'(done), 32'h0);
        check_eq({tag, " err"}, 32'(err), 32'h0);
        check_eq({tag, " timeout"}, 32'(timeout), 32'h0);
        check_eq({tag, " err_count"}, 32'(err_count), 32'h0);
        check_eq({tag, " err_addr"}, 32'(err_addr), 32'h0);
    endtask

    initial begin
        // reset state
        #23;
        check_reset_outputs("reset");
        #4;
        reset_n = 1'b1;
        repeat (2) @(negedge clk_114);

        // mode 10: 8 writes then 8 reads over a correct memory, back-to-back
        mem.delete();
        unwr_good = 1'b0;
        start_run(2'b10, 1'b0, 24'h000100, 16'd8, 4'd0, 16'hA5A5);
        wait_done("wr_rd", 200);
        check_eq("wr_rd accesses", 32'(log_addr.size()), 32'd16);
        if (log_addr.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check_eq($sformatf("wr_rd addr%0d", i), 32'(log_addr[i]), 32'h100 + 32'(i % 8));
                check_eq($sformatf("wr_rd kind%0d", i), 32'(log_st[i]), (i < 8) ? 32'h3 : 32'h2);
            end
            check_eq("wr_rd wdata0", 32'(log_wd[0]), 32'hA4A5);
            check_eq("wr_rd wdata7", 32'(log_wd[7]), 32'hA4A2);
            check_eq("wr_rd back2back", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
        end
        check_eq("wr_rd err", 32'(err), 32'd0);
        check_eq("wr_rd err_count", 32'(err_count), 32'd0);

        // mode 01 over unwritten memory, word 3 corrupted
        mem.delete();
        unwr_good = 1'b1;
        ovr_en = 1'b1; ovr_addr = 24'h000003; ovr_val = 16'h1234;
        start_run(2'b01, 1'b0, 24'h000000, 16'd8, 4'd0, 16'h5A5A);
        wait_done("rdchk", 200);
        check_eq("rdchk accesses", 32'(log_addr.size()), 32'd8);
        check_eq("rdchk err", 32'(err), 32'd1);
        check_eq("rdchk err_count", 32'(err_count), 32'd1);
        check_eq("rdchk err_addr", 32'(err_addr), 32'h000003);
        ovr_en = 1'b0;
        unwr_good = 1'b0;

        // longword pairs, odd length, throttle 2; new start clears the errors
        mem.delete();
        start_run(2'b00, 1'b1, 24'h000040, 16'd5, 4'd2, 16'h0F0F);
        wait_done("lw", 200);
        check_eq("lw accesses", 32'(log_addr.size()), 32'd5);
        if (log_addr.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("lw flag%0d", i), 32'(log_lw[i]), (i == 0 || i == 2) ? 32'd1 : 32'd0);
                check_eq($sformatf("lw addr%0d", i), 32'(log_addr[i]), 32'h40 + 32'(i));
            end
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("lw gap%0d", i), 32'(log_cyc[i+1] - log_cyc[i] - 1), (i % 2 == 0) ? 32'd0 : 32'd2);
        end
        check_eq("lw err cleared", 32'(err), 32'd0);
        check_eq("lw err_count cleared", 32'(err_count), 32'd0);
        check_eq("lw err_addr cleared", 32'(err_addr), 32'd0);

        // throttle 3, with a start pulse while busy that must be ignored
        mem.delete();
        start_run(2'b00, 1'b0, 24'h000200, 16'd4, 4'd3, 16'h1111);
        repeat (3) @(negedge clk_114);
        #1;
        num_words = 16'd1; mode = 2'b01; start = 1'b1;
        @(posedge clk_114);
        #1;
        start = 1'b0;
        wait_done("thr", 200);
        check_eq("thr accesses", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("thr gap%0d", i), 32'(log_cyc[i+1] - log_cyc[i] - 1), 32'd3);
            check_eq("thr kind3", 32'(log_st[3]), 32'h3);
        end

        // mode 11: each write immediately followed by a read of the same word
        mem.delete();
        start_run(2'b11, 1'b0, 24'h000010, 16'd2, 4'd1, 16'h3C3C);
        wait_done("il", 200);
        check_eq("il accesses", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("il kind%0d", i), 32'(log_st[i]), (i % 2 == 0) ? 32'h3 : 32'h2);
                check_eq($sformatf("il addr%0d", i), 32'(log_addr[i]), 32'h10 + 32'(i / 2));
            end
        end
        check_eq("il err", 32'(err), 32'd0);

        // no acknowledge: timeout after 16 clocks, done 17 clocks after issue
        cpuena = 1'b0;
        start_run(2'b00, 1'b0, 24'h000000, 16'd2, 4'd0, 16'h0000);
        wait_done("tmo", 100);
        check_eq("tmo flag", 32'(timeout), 32'd1);
        check_eq("tmo done delay", 32'(done_cyc - issue_cyc), 32'd17);
        check_eq("tmo no completion", 32'(log_addr.size()), 32'd0);
        cpuena = 1'b1;

        // address wrap at 2^24; also clears the timeout flag
        mem.delete();
        start_run(2'b00, 1'b0, 24'hFFFFFE, 16'd4, 4'd0, 16'h2222);
        wait_done("wrap", 200);
        check_eq("wrap timeout cleared", 32'(timeout), 32'd0);
        check_eq("wrap accesses", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            check_eq("wrap addr0", 32'(log_addr[0]), 32'hFFFFFE);
            check_eq("wrap addr1", 32'(log_addr[1]), 32'hFFFFFF);
            check_eq("wrap addr2", 32'(log_addr[2]), 32'h000000);
            check_eq("wrap addr3", 32'(log_addr[3]), 32'h000001);
            check_eq("wrap wdata2", 32'(log_wd[2]), 32'h2222);
        end
        check_eq("wrap err", 32'(err), 32'd0);

        // zero words: straight to done with no bus access
        start_run(2'b10, 1'b0, 24'h000300, 16'd0, 4'd0, 16'h0000);
        wait_done("zero", 20);
        check_eq("zero accesses", 32'(log_addr.size()), 32'd0);

        // reset asserted mid-run
        mem.delete();
        start_run(2'b10, 1'b0, 24'h000500, 16'd8, 4'd1, 16'h7777);
        begin
            bit active = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_114);
                if (cpuState != 2'b01) begin
                    active = 1'b1;
                    break;
                end
            end
            check_eq("rst access seen", 32'(active), 32'd1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk_114);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_114);
        check_eq("midrst no done", 32'(done_cnt), 32'd0);
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst cpuState", 32'(cpuState), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
